ysyx_rd_arb: RTL and testbench



---
 rtl/ysyx_rd_arb_if.sv | 53 +++++
 rtl/ysyx_rd_arb.sv | 160 ++++++++++++++++
 tb/tb_ysyx_rd_arb.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_rd_arb_if.sv
// Shared read-channel bundle: IFU/LSU requester side plus the AXI4 master AR/R channel.
interface ysyx_rd_arb_if #(
   parameter int unsigned DATA_W = 32
);
   logic [DATA_W-1:0] ifu_araddr;
   logic              ifu_arvalid;
   logic [7:0]        ifu_arlen;
   logic [DATA_W-1:0] ifu_rdata_o;
   logic              ifu_rvalid_o;
   logic              ifu_rlast_o;

   logic [DATA_W-1:0] lsu_araddr;
   logic              lsu_arvalid;
   logic [2:0]        lsu_arsize;
   logic [DATA_W-1:0] lsu_rdata_o;
   logic              lsu_rvalid_o;

   logic              rerr_o;

   logic [DATA_W-1:0] m_araddr;
   logic              m_arvalid;
   logic              m_arready;
   logic [7:0]        m_arlen;
   logic [2:0]        m_arsize;
   logic [1:0]        m_arburst;
   logic [3:0]        m_arid;
   logic [63:0]       m_rdata;
   logic              m_rvalid;
   logic              m_rready;
   logic              m_rlast;
   logic [1:0]        m_rresp;
   logic [3:0]        m_rid;

   // Arbiter view: drives the AXI master request and the requester responses.
   modport master (
      input  ifu_araddr, ifu_arvalid, ifu_arlen,
      input  lsu_araddr, lsu_arvalid, lsu_arsize,
      input  m_arready, m_rdata, m_rvalid, m_rlast, m_rresp, m_rid,
      output ifu_rdata_o, ifu_rvalid_o, ifu_rlast_o,
      output lsu_rdata_o, lsu_rvalid_o, rerr_o,
      output m_araddr, m_arvalid, m_arlen, m_arsize, m_arburst, m_arid, m_rready
   );

   // Environment view: requesters and the AXI slave.
   modport slave (
      output ifu_araddr, ifu_arvalid, ifu_arlen,
      output lsu_araddr, lsu_arvalid, lsu_arsize,
      output m_arready, m_rdata, m_rvalid, m_rlast, m_rresp, m_rid,
      input  ifu_rdata_o, ifu_rvalid_o, ifu_rlast_o,
      input  lsu_rdata_o, lsu_rvalid_o, rerr_o,
      input  m_araddr, m_arvalid, m_arlen, m_arsize, m_arburst, m_arid, m_rready
   );
endinterface

// File: rtl/ysyx_rd_arb.sv
// IFU/LSU read-channel arbiter: LSU priority with IFU anti-starvation, one outstanding read.
// Optional YSYX_RD_ARB_PERF_EN adds grant and wait-cycle performance counters.
module ysyx_rd_arb #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 8,
   parameter logic [3:0]  IFU_ID     = 4'd0,
   parameter logic [3:0]  LSU_ID     = 4'd1
) (
   input logic           clk,
   input logic           rst,
   ysyx_rd_arb_if.master bus
`ifdef YSYX_RD_ARB_PERF_EN
   ,
   output logic [31:0]   perf_ifu_grants_o,
   output logic [31:0]   perf_lsu_grants_o,
   output logic [31:0]   perf_wait_cycles_o
`endif
);

   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, AR, R} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [2:0]        size_q, size_d;
   logic [1:0]        burst_q, burst_d;
   logic [3:0]        id_q, id_d;
   logic              sel_ifu_q, sel_ifu_d;
   logic              lane_q, lane_d;
   logic [CNT_W-1:0]  starve_q, starve_d;

   logic              starved;
   logic              lsu_win;
   logic              ifu_grant;
   logic              lsu_grant;
   logic              beat;
   logic [DATA_W-1:0] beat_data;

   assign starved   = (starve_q == CNT_W'(STARVE_MAX));
   assign lsu_win   = bus.lsu_arvalid && !(bus.ifu_arvalid && starved);
   assign beat      = (state_q == R) && bus.m_rvalid;
   assign beat_data = lane_q ? DATA_W'(bus.m_rdata[63:32]) : DATA_W'(bus.m_rdata[31:0]);

   // Next-state: arbitration in IDLE, address handshake in AR, beat tracking in R.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      burst_d   = burst_q;
      id_d      = id_q;
      sel_ifu_d = sel_ifu_q;
      lane_d    = lane_q;
      starve_d  = starve_q;
      ifu_grant = 1'b0;
      lsu_grant = 1'b0;
      case (state_q)
         IDLE: begin
            if (lsu_win) begin
               lsu_grant = 1'b1;
               state_d   = AR;
               addr_d    = bus.lsu_araddr;
               len_d     = 8'd0;
               size_d    = bus.lsu_arsize;
               burst_d   = 2'b01;
               id_d      = LSU_ID;
               sel_ifu_d = 1'b0;
               lane_d    = bus.lsu_araddr[2];
               if (bus.ifu_arvalid && !starved) starve_d = starve_q + CNT_W'(1);
            end else if (bus.ifu_arvalid) begin
               ifu_grant = 1'b1;
               state_d   = AR;
               addr_d    = bus.ifu_araddr;
               len_d     = bus.ifu_arlen;
               size_d    = 3'b010;
               burst_d   = 2'b01;
               id_d      = IFU_ID;
               sel_ifu_d = 1'b1;
               lane_d    = bus.ifu_araddr[2];
               starve_d  = '0;
            end
         end
         AR: begin
            if (bus.m_arready) state_d = R;
         end
         R: begin
            if (bus.m_rvalid) begin
               // A +4 step on the fetch address just flips the 32-bit lane.
               if (sel_ifu_q) lane_d = ~lane_q;
               if (bus.m_rlast) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         id_q      <= '0;
         sel_ifu_q <= 1'b0;
         lane_q    <= 1'b0;
         starve_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         id_q      <= id_d;
         sel_ifu_q <= sel_ifu_d;
         lane_q    <= lane_d;
         starve_q  <= starve_d;
      end
   end

   assign bus.m_araddr  = addr_q;
   assign bus.m_arlen   = len_q;
   assign bus.m_arsize  = size_q;
   assign bus.m_arburst = burst_q;
   assign bus.m_arid    = id_q;
   assign bus.m_arvalid = (state_q == AR);
   assign bus.m_rready  = (state_q == R);

   // Beats go only to the granted requester; data is zeroed when no beat is present.
   assign bus.ifu_rvalid_o = beat && sel_ifu_q;
   assign bus.ifu_rdata_o  = bus.ifu_rvalid_o ? beat_data : '0;
   assign bus.ifu_rlast_o  = bus.ifu_rvalid_o && bus.m_rlast;
   assign bus.lsu_rvalid_o = beat && !sel_ifu_q;
   assign bus.lsu_rdata_o  = bus.lsu_rvalid_o ? beat_data : '0;
   assign bus.rerr_o       = beat && ((bus.m_rresp != 2'b00) || (bus.m_rid != id_q));

`ifdef YSYX_RD_ARB_PERF_EN
   logic [31:0] perf_ifu_q, perf_lsu_q, perf_wait_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_ifu_q  <= '0;
         perf_lsu_q  <= '0;
         perf_wait_q <= '0;
      end else begin
         if (ifu_grant) perf_ifu_q <= perf_ifu_q + 32'd1;
         if (lsu_grant) perf_lsu_q <= perf_lsu_q + 32'd1;
         if ((bus.ifu_arvalid || bus.lsu_arvalid) && (state_q != IDLE))
            perf_wait_q <= perf_wait_q + 32'd1;
      end
   end

   assign perf_ifu_grants_o  = perf_ifu_q;
   assign perf_lsu_grants_o  = perf_lsu_q;
   assign perf_wait_cycles_o = perf_wait_q;
`endif

endmodule

// File: tb/tb_ysyx_rd_arb.sv
// Scoreboard bench for ysyx_rd_arb: directed AR/R stimulus, beats checked by a negedge monitor.
module tb_ysyx_rd_arb;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ysyx_rd_arb_if #(.DATA_W(32)) bus ();
   ysyx_rd_arb dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic        is_ifu;
      logic [31:0] data;
      logic        last;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every forwarded beat must match the oldest expected beat.
   always @(negedge clk) begin
      exp_t e;
      if (bus.ifu_rvalid_o || bus.lsu_rvalid_o) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk("beat_ifu_valid", 64'(bus.ifu_rvalid_o), 64'(e.is_ifu));
            chk("beat_lsu_valid", 64'(bus.lsu_rvalid_o), 64'(!e.is_ifu));
            chk("beat_data", 64'(e.is_ifu ? bus.ifu_rdata_o : bus.lsu_rdata_o), 64'(e.data));
            chk("beat_ifu_last", 64'(bus.ifu_rlast_o), 64'(e.is_ifu & e.last));
            chk("beat_rerr", 64'(bus.rerr_o), 64'(e.err));
         end
      end else if (bus.rerr_o) begin
         chk("rerr_without_beat", 64'd1, 64'd0);
      end
   end

   task automatic ar_accept(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [3:0] id);
      int n = 0;
      @(negedge clk);
      while (!bus.m_arvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_arvalid"}, 64'(bus.m_arvalid), 64'd1);
      if (bus.m_arvalid) begin
         chk({tag, "_araddr"}, 64'(bus.m_araddr), 64'(addr));
         chk({tag, "_arlen"}, 64'(bus.m_arlen), 64'(len));
         chk({tag, "_arsize"}, 64'(bus.m_arsize), 64'(size));
         chk({tag, "_arburst"}, 64'(bus.m_arburst), 64'd1);
         chk({tag, "_arid"}, 64'(bus.m_arid), 64'(id));
         bus.m_arready = 1'b1;
         @(posedge clk);
         #1 bus.m_arready = 1'b0;
      end
   endtask

   task automatic beat(input logic [63:0] d, input logic last, input logic [1:0] resp,
                       input logic [3:0] rid, input logic is_ifu, input logic [31:0] exp_d,
                       input logic exp_err);
      sb_q.push_back('{is_ifu, exp_d, last, exp_err});
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = d;
      bus.m_rlast  = last;
      bus.m_rresp  = resp;
      bus.m_rid    = rid;
      @(posedge clk);
      #1;
      bus.m_rvalid = 1'b0;
      bus.m_rlast  = 1'b0;
      bus.m_rresp  = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.ifu_araddr  = '0;
      bus.ifu_arvalid = 1'b0;
      bus.ifu_arlen   = '0;
      bus.lsu_araddr  = '0;
      bus.lsu_arvalid = 1'b0;
      bus.lsu_arsize  = '0;
      bus.m_arready   = 1'b0;
      bus.m_rdata     = '0;
      bus.m_rvalid    = 1'b0;
      bus.m_rlast     = 1'b0;
      bus.m_rresp     = '0;
      bus.m_rid       = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arvalid", 64'(bus.m_arvalid), 64'd0);
      chk("rst_rready", 64'(bus.m_rready), 64'd0);
      chk("rst_araddr", 64'(bus.m_araddr), 64'd0);
      chk("rst_arburst", 64'(bus.m_arburst), 64'd0);
      chk("rst_rvalids", 64'({bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.rerr_o}), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      // IFU alone, high lane, one-cycle request latency
      bus.ifu_araddr  = 32'h3000_0004;
      bus.ifu_arlen   = 8'd0;
      bus.ifu_arvalid = 1'b1;
      @(negedge clk);
      chk("t1_no_arvalid_yet", 64'(bus.m_arvalid), 64'd0);
      @(negedge clk);
      chk("t1_latency", 64'(bus.m_arvalid), 64'd1);
      ar_accept("t1", 32'h3000_0004, 8'd0, 3'b010, 4'd0);
      beat(64'hAAAA_BBBB_1111_2222, 1'b1, 2'b00, 4'd0, 1'b1, 32'hAAAA_BBBB, 1'b0);
      bus.ifu_arvalid = 1'b0;

      // Simultaneous requests: LSU first, then IFU one cycle after IDLE
      bus.lsu_araddr  = 32'h8000_0000;
      bus.lsu_arsize  = 3'd2;
      bus.ifu_araddr  = 32'h3000_0000;
      bus.ifu_arlen   = 8'd0;
      bus.lsu_arvalid = 1'b1;
      bus.ifu_arvalid = 1'b1;
      ar_accept("t2_lsu", 32'h8000_0000, 8'd0, 3'd2, 4'd1);
      beat(64'h1234_5678_9ABC_DEF0, 1'b1, 2'b00, 4'd1, 1'b0, 32'h9ABC_DEF0, 1'b0);
      bus.lsu_arvalid = 1'b0;
      @(negedge clk);
      chk("t2_idle_gap", 64'(bus.m_arvalid), 64'd0);
      @(negedge clk);
      chk("t2_ifu_latency", 64'(bus.m_arvalid), 64'd1);
      ar_accept("t2_ifu", 32'h3000_0000, 8'd0, 3'b010, 4'd0);
      beat(64'hCAFE_F00D_0BAD_BEEF, 1'b1, 2'b00, 4'd0, 1'b1, 32'h0BAD_BEEF, 1'b0);
      bus.ifu_arvalid = 1'b0;

      // Starvation: eight LSU wins, then IFU is forced, then counter is cleared
      bus.ifu_araddr  = 32'h3000_000C;
      bus.ifu_arlen   = 8'd0;
      bus.lsu_araddr  = 32'h8000_0010;
      bus.lsu_arsize  = 3'd2;
      bus.ifu_arvalid = 1'b1;
      bus.lsu_arvalid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ar_accept("t3_lsu", 32'h8000_0010, 8'd0, 3'd2, 4'd1);
         beat({32'hDEAD_0000 + 32'(i), 32'h1000_0000 + 32'(i)}, 1'b1, 2'b00, 4'd1, 1'b0,
              32'h1000_0000 + 32'(i), 1'b0);
      end
      ar_accept("t3_ifu_forced", 32'h3000_000C, 8'd0, 3'b010, 4'd0);
      beat(64'h5555_6666_7777_8888, 1'b1, 2'b00, 4'd0, 1'b1, 32'h5555_6666, 1'b0);
      ar_accept("t3_lsu_after_clear", 32'h8000_0010, 8'd0, 3'd2, 4'd1);
      beat(64'h0000_0000_4242_4242, 1'b1, 2'b00, 4'd1, 1'b0, 32'h4242_4242, 1'b0);
      bus.lsu_arvalid = 1'b0;
      ar_accept("t3_ifu_again", 32'h3000_000C, 8'd0, 3'b010, 4'd0);
      beat(64'h0101_0101_0202_0202, 1'b1, 2'b00, 4'd0, 1'b1, 32'h0101_0101, 1'b0);
      bus.ifu_arvalid = 1'b0;

      // IFU 4-beat burst: lanes low/high/low/high, rlast on the last beat only
      bus.ifu_araddr  = 32'h3000_0000;
      bus.ifu_arlen   = 8'd3;
      bus.ifu_arvalid = 1'b1;
      ar_accept("t4", 32'h3000_0000, 8'd3, 3'b010, 4'd0);
      beat(64'hB0B0_0001_A0A0_0000, 1'b0, 2'b00, 4'd0, 1'b1, 32'hA0A0_0000, 1'b0);
      beat(64'hB1B1_0001_A1A1_0000, 1'b0, 2'b00, 4'd0, 1'b1, 32'hB1B1_0001, 1'b0);
      beat(64'hB2B2_0001_A2A2_0000, 1'b0, 2'b00, 4'd0, 1'b1, 32'hA2A2_0000, 1'b0);
      beat(64'hB3B3_0001_A3A3_0000, 1'b1, 2'b00, 4'd0, 1'b1, 32'hB3B3_0001, 1'b0);
      bus.ifu_arvalid = 1'b0;
      @(negedge clk);
      chk("t4_back_idle", 64'({bus.m_arvalid, bus.m_rready}), 64'd0);

      // Error beats: bad rresp, then bad rid; data still delivered
      bus.lsu_araddr  = 32'h8000_0004;
      bus.lsu_arsize  = 3'd2;
      bus.lsu_arvalid = 1'b1;
      ar_accept("t5_resp", 32'h8000_0004, 8'd0, 3'd2, 4'd1);
      beat(64'h1111_2222_3333_4444, 1'b1, 2'b10, 4'd1, 1'b0, 32'h1111_2222, 1'b1);
      bus.lsu_arvalid = 1'b0;
      @(negedge clk);
      chk("t5_rerr_pulse", 64'(bus.rerr_o), 64'd0);
      bus.lsu_araddr  = 32'h8000_0000;
      bus.lsu_arsize  = 3'd1;
      bus.lsu_arvalid = 1'b1;
      ar_accept("t5_rid", 32'h8000_0000, 8'd0, 3'd1, 4'd1);
      beat(64'h9999_8888_7777_6666, 1'b1, 2'b00, 4'd5, 1'b0, 32'h7777_6666, 1'b1);
      bus.lsu_arvalid = 1'b0;

      // Reset in the middle of a burst, then a clean LSU read
      bus.ifu_araddr  = 32'h3000_0000;
      bus.ifu_arlen   = 8'd3;
      bus.ifu_arvalid = 1'b1;
      ar_accept("t6_ifu", 32'h3000_0000, 8'd3, 3'b010, 4'd0);
      beat(64'hC0C0_0000_D0D0_0000, 1'b0, 2'b00, 4'd0, 1'b1, 32'hD0D0_0000, 1'b0);
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = 64'hC1C1_0000_D1D1_0000;
      rst = 1'b0;
      #1;
      chk("t6_rst_rready", 64'(bus.m_rready), 64'd0);
      chk("t6_rst_arvalid", 64'(bus.m_arvalid), 64'd0);
      chk("t6_rst_ifu_out", 64'({bus.ifu_rvalid_o, bus.ifu_rlast_o, bus.ifu_rdata_o}), 64'd0);
      chk("t6_rst_fields", 64'({bus.m_araddr, bus.m_arlen, bus.m_arid}), 64'd0);
      chk("t6_rst_rerr", 64'(bus.rerr_o), 64'd0);
      bus.m_rvalid    = 1'b0;
      bus.ifu_arvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      bus.lsu_araddr  = 32'h8000_0004;
      bus.lsu_arsize  = 3'd2;
      bus.lsu_arvalid = 1'b1;
      ar_accept("t6_lsu", 32'h8000_0004, 8'd0, 3'd2, 4'd1);
      beat(64'hFEED_FACE_0000_0000, 1'b1, 2'b00, 4'd1, 1'b0, 32'hFEED_FACE, 1'b0);
      bus.lsu_arvalid = 1'b0;

      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
